// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM among N_REQ requesters.
// Registered grant/en/addr toward the ROM; a one-hot delay line tags returning data.
module rom_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int N_REQ      = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic [N_REQ-1:0]            req_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0] addr_i,
    output logic [N_REQ-1:0]            gnt_o,
    output logic [N_REQ-1:0]            valid_o,
    output logic [DATA_WIDTH-1:0]       data_o,
    output logic                        rom_en_o,
    output logic [ADDR_WIDTH-1:0]       rom_addr_o,
    input  logic [DATA_WIDTH-1:0]       rom_data_i
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(N_REQ - 1);

    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [N_REQ-1:0]      gnt_q, gnt_d;
    logic                  rom_en_q, rom_en_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [N_REQ-1:0]      vld_q [RD_LATENCY];
    logic [N_REQ-1:0]      vld_d [RD_LATENCY];

    logic [ADDR_WIDTH-1:0] addr_arr [N_REQ];
    logic [N_REQ-1:0]      eligible;
    logic                  found;
    logic [PTR_W-1:0]      winner;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_addr
            assign addr_arr[gi] = addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
        end
    endgenerate

    // A requester is blind to its own req_i during its grant cycle.
    assign eligible = req_i & ~gnt_q;

    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        for (int i = 1; i <= N_REQ; i++) begin
            int idx;
            idx = (int'(ptr_q) + i) % N_REQ;
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        gnt_d      = '0;
        rom_en_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        ptr_d      = ptr_q;
        if (found) begin
            gnt_d[winner] = 1'b1;
            rom_en_d      = 1'b1;
            rom_addr_d    = addr_arr[winner];
            ptr_d         = winner;
        end
    end

    // Grant delayed by RD_LATENCY lines up with the ROM's data return.
    always_comb begin
        vld_d[0] = gnt_q;
        for (int s = 1; s < RD_LATENCY; s++) begin
            vld_d[s] = vld_q[s-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q      <= PTR_RST;
            gnt_q      <= '0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            for (int s = 0; s < RD_LATENCY; s++) begin
                vld_q[s] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            rom_en_q   <= rom_en_d;
            rom_addr_q <= rom_addr_d;
            for (int s = 0; s < RD_LATENCY; s++) begin
                vld_q[s] <= vld_d[s];
            end
        end
    end

    assign gnt_o      = gnt_q;
    assign rom_en_o   = rom_en_q;
    assign rom_addr_o = rom_addr_q;
    assign valid_o    = vld_q[RD_LATENCY-1];
    assign data_o     = rom_data_i;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: one instance at RD_LATENCY=1, one at RD_LATENCY=3,
// each with a behavioural ROM where ROM[a] = a[7:0] ^ 8'h5A.
module tb_rom_arbiter;

    localparam int AW = 10;
    localparam int DW = 8;
    localparam int NR = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [NR-1:0]     req;
    logic [NR*AW-1:0]  addr;
    logic [NR-1:0]     gnt, vld;
    logic [DW-1:0]     dout, rom_data;
    logic              rom_en;
    logic [AW-1:0]     rom_addr;

    logic              rst3_n;
    logic [NR-1:0]     req3;
    logic [NR*AW-1:0]  addr3;
    logic [NR-1:0]     gnt3, vld3;
    logic [DW-1:0]     dout3, rom3_s1, rom3_s2, rom3_s3;
    logic              rom_en3;
    logic [AW-1:0]     rom_addr3;

    int total = 0;
    int bad   = 0;

    rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_REQ(NR), .RD_LATENCY(1)) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .addr_i(addr),
        .gnt_o(gnt), .valid_o(vld), .data_o(dout),
        .rom_en_o(rom_en), .rom_addr_o(rom_addr), .rom_data_i(rom_data)
    );

    rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_REQ(NR), .RD_LATENCY(3)) u_dut3 (
        .clk_i(clk), .rst_n_i(rst3_n), .req_i(req3), .addr_i(addr3),
        .gnt_o(gnt3), .valid_o(vld3), .data_o(dout3),
        .rom_en_o(rom_en3), .rom_addr_o(rom_addr3), .rom_data_i(rom3_s3)
    );

    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_f(rom_addr);
    end

    always @(posedge clk) begin
        if (rom_en3) rom3_s1 <= rom_f(rom_addr3);
        rom3_s2 <= rom3_s1;
        rom3_s3 <= rom3_s2;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [NR-1:0] exp_gnt [5];
    logic [DW-1:0] exp_dat [5];

    initial begin
        rst_n = 1'b1; rst3_n = 1'b1;
        req = '0; req3 = '0; addr = '0; addr3 = '0;
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_dat = '{8'h4B, 8'h78, 8'h69, 8'h1E, 8'h4B};
        #2;
        rst_n = 1'b0; rst3_n = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_valid", 32'(vld), 32'h0);
        chk("rst_en", 32'(rom_en), 32'h0);
        chk("rst_addr", 32'(rom_addr), 32'h0);
        step(); step();
        rst_n = 1'b1; rst3_n = 1'b1;

        // 1: idle after reset
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_en", 32'(rom_en), 32'h0);
            chk("idle_gnt", 32'(gnt), 32'h0);
        end
        chk("idle_valid", 32'(vld), 32'h0);

        // 2: single request from requester 2
        req = 4'b0100;
        addr[2*AW +: AW] = 10'h015;
        step();
        chk("single_gnt", 32'(gnt), 32'h4);
        chk("single_en", 32'(rom_en), 32'h1);
        chk("single_addr", 32'(rom_addr), 32'h015);
        chk("single_valid_early", 32'(vld), 32'h0);
        req = '0;
        step();
        chk("single_valid", 32'(vld), 32'h4);
        chk("single_data", 32'(dout), 32'h4F);
        chk("single_gnt_off", 32'(gnt), 32'h0);
        chk("single_en_off", 32'(rom_en), 32'h0);
        chk("single_addr_hold", 32'(rom_addr), 32'h015);

        // 3: all four requesting after a fresh reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        addr[0*AW +: AW] = 10'h011;
        addr[1*AW +: AW] = 10'h122;
        addr[2*AW +: AW] = 10'h233;
        addr[3*AW +: AW] = 10'h344;
        req = 4'b1111;
        step();
        chk("rr_gnt0", 32'(gnt), 32'(exp_gnt[0]));
        chk("rr_addr0", 32'(rom_addr), 32'h011);
        chk("rr_valid0", 32'(vld), 32'h0);
        for (int i = 1; i < 5; i++) begin
            step();
            chk("rr_gnt", 32'(gnt), 32'(exp_gnt[i]));
            chk("rr_en", 32'(rom_en), 32'h1);
            chk("rr_valid", 32'(vld), 32'(exp_gnt[i-1]));
            chk("rr_data", 32'(dout), 32'(exp_dat[i-1]));
        end
        req = '0;
        step();
        chk("rr_tail_valid", 32'(vld), 32'(exp_gnt[4]));
        chk("rr_tail_data", 32'(dout), 32'(exp_dat[4]));
        chk("rr_tail_en", 32'(rom_en), 32'h0);

        // 4: last grant to 1, then 1 and 3 together -> 3 first
        req = 4'b0010;
        addr[1*AW +: AW] = 10'h100;
        step();
        chk("p4_gnt1", 32'(gnt), 32'h2);
        req = 4'b1010;
        step();
        chk("p4_gnt3", 32'(gnt), 32'h8);
        chk("p4_addr3", 32'(rom_addr), 32'h344);
        step();
        chk("p4_gnt1_again", 32'(gnt), 32'h2);
        chk("p4_addr1", 32'(rom_addr), 32'h100);
        req = '0;
        step();
        chk("p4_idle", 32'(gnt), 32'h0);

        // 5: requester 0 held -> grant every other cycle
        req = 4'b0001;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("hold_gnt", 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h0);
        end
        req = '0;
        step();
        chk("hold_stop", 32'(gnt), 32'h0);

        // 6: RD_LATENCY=3, reset drops the in-flight access
        req3 = 4'b0001;
        addr3[0*AW +: AW] = 10'h0AA;
        step();
        chk("l3_gnt", 32'(gnt3), 32'h1);
        chk("l3_en", 32'(rom_en3), 32'h1);
        req3 = '0;
        step();
        rst3_n = 1'b0;
        #1;
        chk("l3_rst_valid", 32'(vld3), 32'h0);
        step();
        rst3_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("l3_no_valid", 32'(vld3), 32'h0);
            step();
        end

        req3 = 4'b0001;
        step();
        chk("l3b_gnt", 32'(gnt3), 32'h1);
        chk("l3b_en", 32'(rom_en3), 32'h1);
        req3 = '0;
        step();
        chk("l3b_v1", 32'(vld3), 32'h0);
        step();
        chk("l3b_v2", 32'(vld3), 32'h0);
        step();
        chk("l3b_v3", 32'(vld3), 32'h1);
        chk("l3b_data", 32'(dout3), 32'hF0);
        step();
        chk("l3b_v4", 32'(vld3), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
